pixel_readout_rx: RTL and testbench

//  Receiving end of the pixel array's tristate read-out buses. Samples pixData1..4 while a

---
 rtl/pixel_readout_pkg.sv | 18 +
 rtl/pixel_readout_fifo.sv | 68 ++++++
 rtl/pixel_readout_rx.sv | 160 ++++++++++++++++
 tb/tb_pixel_readout_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_readout_pkg.sv
// Shared types and constants for the pixel read-out receive path.
package pixel_readout_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned N_ROWS = 4;

  typedef enum logic {
    IDLE,
    PUSH
  } rx_state_t;

  typedef struct packed {
    logic             first;
    logic             last;
    logic [PIX_W-1:0] data;
  } pix_entry_t;

endpackage

// File: rtl/pixel_readout_fifo.sv
// Single-clock FIFO of pixel entries with a registered head and a free-slot count.
module pixel_readout_fifo
  import pixel_readout_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  pix_entry_t                   wr_entry,
  input  logic                         pop,
  output pix_entry_t                   head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   free
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  pix_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  pix_entry_t    head_q, head_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && valid_q;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    valid_d  = (count_d != '0);
    // Head is preloaded so it is valid the cycle after a push into an empty FIFO
    head_d   = '0;
    if ((count_q - CW'(do_pop)) == '0) begin
      if (do_push) head_d = wr_entry;
    end else begin
      head_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign free  = CW'(DEPTH) - count_q;

endmodule

// File: rtl/pixel_readout_rx.sv
// Pixel read-out receiver: captures rows on read-strobe falls and streams pixels out.
// Optional PIXEL_READOUT_RX_DROPCNT_EN adds a saturating drop_count output.
module pixel_readout_rx
  import pixel_readout_pkg::*;
#(
  parameter int unsigned N_COLS     = 4,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read1,
  input  logic             read2,
  input  logic             read3,
  input  logic             read4,
  input  logic [PIX_W-1:0] pixData1,
  input  logic [PIX_W-1:0] pixData2,
  input  logic [PIX_W-1:0] pixData3,
  input  logic [PIX_W-1:0] pixData4,
  output logic [PIX_W-1:0] pixelDataOut,
  output logic             pixel_valid,
  input  logic             pixel_ready,
  output logic             pixel_first,
  output logic             pixel_last,
  output logic             row_drop,
`ifdef PIXEL_READOUT_RX_DROPCNT_EN
  output logic [7:0]       drop_count,
`endif
  output logic             proto_err
);

  localparam int unsigned CW   = $clog2(FIFO_DEPTH+1);
  localparam int unsigned IDXW = $clog2(N_ROWS);
  localparam int unsigned CLW  = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  logic [N_ROWS-1:0] strb;
  logic [PIX_W-1:0]  bus [4];
  logic              any_hi, fall, accept;
  logic [IDXW-1:0]   idx;

  rx_state_t         state_q, state_d;
  logic              act_q, act_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [PIX_W-1:0]  sample_q [N_COLS];
  logic [PIX_W-1:0]  sample_d [N_COLS];
  logic [PIX_W-1:0]  snap_q [N_COLS];
  logic [PIX_W-1:0]  snap_d [N_COLS];
  logic [IDXW-1:0]   snap_row_q, snap_row_d;
  logic [CLW-1:0]    col_q, col_d;

  logic              push;
  pix_entry_t        wr_entry, head;
  logic [CW-1:0]     free;

  assign strb = {read4, read3, read2, read1};
  assign bus  = '{pixData1, pixData2, pixData3, pixData4};

  always_comb begin
    any_hi = |strb;
    idx    = '0;
    for (int unsigned i = N_ROWS; i > 0; i--) begin
      if (strb[i-1]) idx = IDXW'(i - 1);
    end
    proto_err = ($countones(strb) > 1);
    act_d     = any_hi;
    idx_d     = idx;
    sample_d  = sample_q;
    if (any_hi) begin
      for (int unsigned c = 0; c < N_COLS; c++) sample_d[c] = bus[c];
    end
    fall     = act_q && !strb[idx_q];
    accept   = fall && (state_q == IDLE) && (free >= CW'(N_COLS));
    row_drop = fall && !accept;
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    snap_d     = snap_q;
    snap_row_d = snap_row_q;
    push       = 1'b0;
    wr_entry   = '0;
    case (state_q)
      IDLE: begin
        // Snapshot only on accept so a dropped row cannot corrupt a row being pushed
        if (accept) begin
          push           = 1'b1;
          wr_entry.data  = sample_q[0];
          wr_entry.first = (idx_q == '0);
          wr_entry.last  = (idx_q == IDXW'(N_ROWS - 1)) && (N_COLS == 1);
          snap_d         = sample_q;
          snap_row_d     = idx_q;
          col_d          = CLW'(1);
          state_d        = (N_COLS > 1) ? PUSH : IDLE;
        end
      end
      PUSH: begin
        push           = 1'b1;
        wr_entry.data  = snap_q[col_q];
        wr_entry.last  = (snap_row_q == IDXW'(N_ROWS - 1)) && (col_q == CLW'(N_COLS - 1));
        col_d          = col_q + CLW'(1);
        if (col_q == CLW'(N_COLS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      act_q      <= 1'b0;
      idx_q      <= '0;
      sample_q   <= '{default: '0};
      snap_q     <= '{default: '0};
      snap_row_q <= '0;
      col_q      <= '0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      idx_q      <= idx_d;
      sample_q   <= sample_d;
      snap_q     <= snap_d;
      snap_row_q <= snap_row_d;
      col_q      <= col_d;
    end
  end

  pixel_readout_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pixel_ready),
    .head     (head),
    .valid    (pixel_valid),
    .free     (free)
  );

  assign pixelDataOut = head.data;
  assign pixel_first  = head.first;
  assign pixel_last   = head.last;

`ifdef PIXEL_READOUT_RX_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (row_drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_readout_rx.sv
// Self-checking bench for pixel_readout_rx: directed scenarios plus random strobes against a queue model.
module tb_pixel_readout_rx;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic       first;
    logic       last;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] strb;
  logic [7:0] bus [4];
  logic       pixel_ready;
  logic [7:0] pixelDataOut;
  logic       pixel_valid, pixel_first, pixel_last, row_drop, proto_err;
`ifdef PIXEL_READOUT_RX_DROPCNT_EN
  logic [7:0] drop_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  exp_t       expq[$];
  exp_t       pending[$];
  logic [7:0] rx_log[$];
  logic [7:0] last_bus [4];
  int         prev_idx = -1;
  int         drops    = 0;
  bit         tog      = 1'b0;

  always #5 clk = ~clk;

  pixel_readout_rx #(
    .N_COLS     (4),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .read1        (strb[0]),
    .read2        (strb[1]),
    .read3        (strb[2]),
    .read4        (strb[3]),
    .pixData1     (bus[0]),
    .pixData2     (bus[1]),
    .pixData3     (bus[2]),
    .pixData4     (bus[3]),
    .pixelDataOut (pixelDataOut),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .pixel_first  (pixel_first),
    .pixel_last   (pixel_last),
    .row_drop     (row_drop),
`ifdef PIXEL_READOUT_RX_DROPCNT_EN
    .drop_count   (drop_count),
`endif
    .proto_err    (proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    expq.delete();
    pending.delete();
    prev_idx = -1;
    drops    = 0;
    for (int c = 0; c < 4; c++) last_bus[c] = '0;
  endtask

  // One cycle of the reference: a row ends when the strobe that owned the bus goes low.
  task automatic eval();
    int   idx = -1;
    int   nh  = 0;
    bit   fall, acc, exp_drop;
    exp_t e;
    for (int i = 3; i >= 0; i--) begin
      if (strb[i]) begin
        idx = i;
        nh++;
      end
    end
    fall = (prev_idx >= 0) && !strb[prev_idx];
    acc  = 1'b0;
    if (fall && pending.size() == 0 && (DEPTH - expq.size()) >= 4) begin
      acc = 1'b1;
      for (int c = 0; c < 4; c++) begin
        e.first = (prev_idx == 0) && (c == 0);
        e.last  = (prev_idx == 3) && (c == 3);
        e.data  = last_bus[c];
        pending.push_back(e);
      end
    end
    exp_drop = fall && !acc;
    if (exp_drop && drops < 255) drops++;
    if (idx >= 0) begin
      for (int c = 0; c < 4; c++) last_bus[c] = bus[c];
    end
    prev_idx = idx;

    chk("proto_err", 32'(proto_err), 32'(nh > 1));
    chk("row_drop", 32'(row_drop), 32'(exp_drop));
    chk("pixel_valid", 32'(pixel_valid), 32'(expq.size() > 0));
    if (expq.size() > 0) chk("head", 32'({pixel_first, pixel_last, pixelDataOut}), 32'(expq[0]));
`ifdef PIXEL_READOUT_RX_DROPCNT_EN
    chk("drop_count", 32'(drop_count), 32'(drops));
`endif
    if (pixel_valid && pixel_ready) rx_log.push_back(pixelDataOut);
    if (expq.size() > 0 && pixel_ready) void'(expq.pop_front());
    if (pending.size() > 0) expq.push_back(pending.pop_front());
  endtask

  task automatic step();
    if (tog) pixel_ready = ~pixel_ready;
    @(negedge clk);
    if (reset) begin
      chk("rst_valid", 32'(pixel_valid), 32'd0);
      chk("rst_head", 32'({pixel_first, pixel_last, pixelDataOut}), 32'd0);
      chk("rst_drop", 32'(row_drop), 32'd0);
`ifdef PIXEL_READOUT_RX_DROPCNT_EN
      chk("rst_drop_count", 32'(drop_count), 32'd0);
`endif
      model_clear();
    end else begin
      eval();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_row(input int k, input int len);
    for (int i = 0; i < len; i++) begin
      strb = 4'b0001 << k;
      for (int c = 0; c < 4; c++) bus[c] = 8'(16 * (k + 1) + c);
      step();
    end
  endtask

  task automatic idle(input int n);
    strb = '0;
    repeat (n) step();
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, "_count"}, 32'(rx_log.size()), 32'd16);
    for (int i = 0; i < rx_log.size() && i < 16; i++)
      chk({tag, "_order"}, 32'(rx_log[i]), 32'(16 * (i / 4 + 1) + i % 4));
  endtask

  initial begin
    reset       = 1'b1;
    strb        = '0;
    pixel_ready = 1'b0;
    for (int c = 0; c < 4; c++) bus[c] = '0;
    model_clear();
    repeat (2) step();
    reset = 1'b0;

    // Reset lands one cycle into a row push; nothing may survive it
    read_row(0, 3);
    idle(1);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    pixel_ready = 1'b1;
    idle(8);

    // Full frame, consumer always ready
    rx_log.delete();
    for (int k = 0; k < 4; k++) read_row(k, 5);
    idle(12);
    chk_frame("t2");

    // Consumer stalled: four rows fill the FIFO, a fifth is dropped
    reset = 1'b1;
    step();
    reset = 1'b0;
    pixel_ready = 1'b0;
    for (int k = 0; k < 4; k++) read_row(k, 5);
    idle(2);
    read_row(0, 2);
    idle(2);
`ifdef PIXEL_READOUT_RX_DROPCNT_EN
    chk("t3_drop_count", 32'(drop_count), 32'd1);
`endif
    rx_log.delete();
    pixel_ready = 1'b1;
    idle(20);
    chk_frame("t3");

    // Second strobe falls while the first row is still being pushed
    rx_log.delete();
    read_row(0, 2);
    idle(1);
    read_row(1, 1);
    idle(10);
    chk("t4_count", 32'(rx_log.size()), 32'd4);
    for (int i = 0; i < rx_log.size() && i < 4; i++)
      chk("t4_data", 32'(rx_log[i]), 32'(16 + i));

    // Two strobes together: protocol error, lower strobe owns the row
    rx_log.delete();
    strb = 4'b0011;
    for (int c = 0; c < 4; c++) bus[c] = 8'(8'h50 + c);
    step();
    idle(8);
    chk("t5_count", 32'(rx_log.size()), 32'd4);

    // Consumer toggling ready every cycle
    rx_log.delete();
    tog = 1'b1;
    for (int k = 0; k < 4; k++) read_row(k, 5);
    idle(30);
    tog = 1'b0;
    chk_frame("t6");

    // Random strobe patterns, bus data and back-pressure
    strb = '0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int r = $urandom_range(0, 9);
        if (r < 4)      strb = '0;
        else if (r < 9) strb = 4'b0001 << $urandom_range(0, 3);
        else            strb = 4'($urandom_range(1, 15));
      end
      for (int c = 0; c < 4; c++) bus[c] = 8'($urandom_range(0, 255));
      pixel_ready = ((n / 64) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step();
    end
    pixel_ready = 1'b1;
    idle(40);
    chk("final_valid", 32'(pixel_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
